// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mips_pkg : constants and types shared by fetch, decode and the hazard unit. |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
package mips_pkg;

    localparam int DATA_W_DEF = 23;
    localparam int ADDR_W_DEF = 23;
    localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = '0;
    localparam logic [DATA_W_DEF-1:0] NOP = '0;

    typedef enum logic [0:0] {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_stage_if : instruction-memory request/response bundle.                |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
interface fetch_stage_if #(
    parameter int DATA_W = 23,
    parameter int ADDR_W = 23
);
    logic              IMem_Req;
    logic [ADDR_W-1:0] IMem_Addr;
    logic              IMem_Ready;
    logic [DATA_W-1:0] IMem_Data;

    modport master (
        output IMem_Req,
        output IMem_Addr,
        input  IMem_Ready,
        input  IMem_Data
    );

    modport slave (
        input  IMem_Req,
        input  IMem_Addr,
        output IMem_Ready,
        output IMem_Data
    );
endinterface
`default_nettype wire

// File: rtl/ifid_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ifid_reg : IF/ID pipeline register with write enable and flush to bubble.   |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module ifid_reg #(
    parameter int DATA_W = 23,
    parameter int ADDR_W = 23
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_we,
    input  wire logic              i_flush,
    input  wire logic [DATA_W-1:0] i_instr,
    input  wire logic [ADDR_W-1:0] i_pcplus1,
    input  wire logic              i_valid,
    output logic      [DATA_W-1:0] o_instr,
    output logic      [ADDR_W-1:0] o_pcplus1,
    output logic                   o_valid
);

    logic [DATA_W-1:0] r_instr;
    logic [ADDR_W-1:0] r_pcplus1;
    logic              r_valid;

    // Flush wins over write enable so a redirect always leaves a bubble.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_instr   <= '0;
            r_pcplus1 <= '0;
            r_valid   <= 1'b0;
        end else if (i_we) begin
            r_instr   <= i_instr;
            r_pcplus1 <= i_pcplus1;
            r_valid   <= i_valid;
        end
    end

    assign o_instr   = r_instr;
    assign o_pcplus1 = r_pcplus1;
    assign o_valid   = r_valid;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_stage : PC, instruction-memory handshake, hold buffer and IF/ID reg.  |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module fetch_stage
    import mips_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              PCWriteEn,
    input  wire logic              IFID_WriteEn,
    input  wire logic              Redirect,
    input  wire logic [ADDR_W-1:0] Redirect_Target,
    fetch_stage_if.master          imem,
    output logic      [DATA_W-1:0] IFID_Instr,
    output logic      [ADDR_W-1:0] IFID_PCPlus1,
    output logic                   IFID_Valid
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [DATA_W-1:0] r_hold;
    logic [DATA_W-1:0] w_hold_nxt;

    logic              w_advance;
    logic              w_redirect;
    logic [ADDR_W-1:0] w_pc_plus1;
    logic [DATA_W-1:0] w_load_instr;
    logic [ADDR_W-1:0] w_load_pcp1;
    logic              w_load_valid;

    assign w_advance  = PCWriteEn & IFID_WriteEn;
    // A stalled ID instruction has no final branch outcome, so only accept when it moves on.
    assign w_redirect = Redirect & IFID_Valid & w_advance;
    assign w_pc_plus1 = r_pc + ADDR_W'(1);

    assign imem.IMem_Req  = (r_state == S_REQ) & ~rst;
    assign imem.IMem_Addr = r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_hold_nxt   = r_hold;
        w_load_instr = DATA_W'(NOP);
        w_load_pcp1  = '0;
        w_load_valid = 1'b0;
        if (w_redirect) begin
            w_pc_nxt    = Redirect_Target;
            w_hold_nxt  = '0;
            w_state_nxt = S_REQ;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (imem.IMem_Ready) begin
                        if (w_advance) begin
                            w_pc_nxt     = w_pc_plus1;
                            w_load_instr = imem.IMem_Data;
                            w_load_pcp1  = w_pc_plus1;
                            w_load_valid = 1'b1;
                        end else begin
                            w_hold_nxt  = imem.IMem_Data;
                            w_state_nxt = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_advance) begin
                        w_pc_nxt     = w_pc_plus1;
                        w_load_instr = r_hold;
                        w_load_pcp1  = w_pc_plus1;
                        w_load_valid = 1'b1;
                        w_state_nxt  = S_REQ;
                    end
                end
                default: w_state_nxt = S_REQ;
            endcase
        end
    end

    // Writing with the default (bubble) load covers the not-ready-but-advancing case.
    ifid_reg #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ifid_reg (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_advance),
        .i_flush   (w_redirect),
        .i_instr   (w_load_instr),
        .i_pcplus1 (w_load_pcp1),
        .i_valid   (w_load_valid),
        .o_instr   (IFID_Instr),
        .o_pcplus1 (IFID_PCPlus1),
        .o_valid   (IFID_Valid)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_stage : directed self-checking bench for fetch_stage.              |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fetch_stage;

    localparam int DW = 23;
    localparam int AW = 23;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          PCWriteEn = 1'b1;
    logic          IFID_WriteEn = 1'b1;
    logic          Redirect = 1'b0;
    logic [AW-1:0] Redirect_Target = '0;
    logic [DW-1:0] IFID_Instr;
    logic [AW-1:0] IFID_PCPlus1;
    logic          IFID_Valid;

    logic          r_ready = 1'b1;
    logic          r_ovr_en = 1'b0;
    logic [DW-1:0] r_ovr_data = '0;

    int checks = 0;
    int errors = 0;

    fetch_stage_if #(.DATA_W(DW), .ADDR_W(AW)) imem ();

    // Memory model: word k holds k+100 unless an override is active.
    assign imem.IMem_Ready = r_ready;
    assign imem.IMem_Data  = r_ovr_en ? r_ovr_data : DW'(imem.IMem_Addr + AW'(100));

    fetch_stage #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC('0)) dut (
        .clk             (clk),
        .rst             (rst),
        .PCWriteEn       (PCWriteEn),
        .IFID_WriteEn    (IFID_WriteEn),
        .Redirect        (Redirect),
        .Redirect_Target (Redirect_Target),
        .imem            (imem.master),
        .IFID_Instr      (IFID_Instr),
        .IFID_PCPlus1    (IFID_PCPlus1),
        .IFID_Valid      (IFID_Valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (IFID_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", IFID_Valid); end
        checks++; if (IFID_Instr !== 23'd0) begin errors++; $display("FAIL reset_instr got %0h exp 0", IFID_Instr); end
        checks++; if (IFID_PCPlus1 !== 23'd0) begin errors++; $display("FAIL reset_pcp1 got %0h exp 0", IFID_PCPlus1); end
        checks++; if (imem.IMem_Req !== 1'b0) begin errors++; $display("FAIL reset_req got %0h exp 0", imem.IMem_Req); end
        rst = 1'b0;
        #1;
        checks++; if (imem.IMem_Req !== 1'b1) begin errors++; $display("FAIL post_reset_req got %0h exp 1", imem.IMem_Req); end
        checks++; if (imem.IMem_Addr !== 23'd0) begin errors++; $display("FAIL post_reset_addr got %0h exp 0", imem.IMem_Addr); end
    endtask

    task automatic test_sequential();
        r_ready = 1'b1; PCWriteEn = 1'b1; IFID_WriteEn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (imem.IMem_Addr !== AW'(k)) begin errors++; $display("FAIL seq_addr[%0d] got %0h exp %0h", k, imem.IMem_Addr, k); end
            tick();
            checks++; if (IFID_Instr !== DW'(k + 100)) begin errors++; $display("FAIL seq_instr[%0d] got %0d exp %0d", k, IFID_Instr, k + 100); end
            checks++; if (IFID_PCPlus1 !== AW'(k + 1)) begin errors++; $display("FAIL seq_pcp1[%0d] got %0d exp %0d", k, IFID_PCPlus1, k + 1); end
            checks++; if (IFID_Valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] got %0h exp 1", k, IFID_Valid); end
        end
    endtask

    task automatic test_stall();
        tick(); // PC=4 instruction into IF/ID: 104 / 5
        checks++; if (IFID_Instr !== 23'd104) begin errors++; $display("FAIL stall_pre_instr got %0d exp 104", IFID_Instr); end
        r_ovr_en = 1'b1; r_ovr_data = 23'd7;
        PCWriteEn = 1'b0; IFID_WriteEn = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (c == 0) r_ovr_en = 1'b0;
            checks++; if (IFID_Instr !== 23'd104 || IFID_PCPlus1 !== 23'd5 || IFID_Valid !== 1'b1) begin
                errors++; $display("FAIL stall_hold[%0d] got %0d/%0d/%0h exp 104/5/1", c, IFID_Instr, IFID_PCPlus1, IFID_Valid); end
            checks++; if (imem.IMem_Req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d] got %0h exp 0", c, imem.IMem_Req); end
            checks++; if (imem.IMem_Addr !== 23'd5) begin errors++; $display("FAIL stall_addr[%0d] got %0d exp 5", c, imem.IMem_Addr); end
        end
        PCWriteEn = 1'b1; IFID_WriteEn = 1'b1;
        tick();
        checks++; if (IFID_Instr !== 23'd7) begin errors++; $display("FAIL stall_release_instr got %0d exp 7", IFID_Instr); end
        checks++; if (IFID_PCPlus1 !== 23'd6) begin errors++; $display("FAIL stall_release_pcp1 got %0d exp 6", IFID_PCPlus1); end
        checks++; if (imem.IMem_Addr !== 23'd6 || imem.IMem_Req !== 1'b1) begin
            errors++; $display("FAIL stall_release_addr got %0d req %0h exp 6 req 1", imem.IMem_Addr, imem.IMem_Req); end
    endtask

    task automatic test_redirect();
        Redirect = 1'b1; Redirect_Target = 23'h40;
        tick();
        Redirect = 1'b0;
        checks++; if (IFID_Valid !== 1'b0 || IFID_Instr !== 23'd0) begin
            errors++; $display("FAIL redir_bubble got valid %0h instr %0h exp 0/0", IFID_Valid, IFID_Instr); end
        checks++; if (imem.IMem_Addr !== 23'h40) begin errors++; $display("FAIL redir_addr got %0h exp 40", imem.IMem_Addr); end
        tick();
        checks++; if (IFID_PCPlus1 !== 23'h41 || IFID_Instr !== 23'd164 || IFID_Valid !== 1'b1) begin
            errors++; $display("FAIL redir_target got %0h/%0d/%0h exp 41/164/1", IFID_PCPlus1, IFID_Instr, IFID_Valid); end
    endtask

    task automatic test_redirect_ignored();
        IFID_WriteEn = 1'b0; Redirect = 1'b1; Redirect_Target = 23'h10;
        tick();
        Redirect = 1'b0;
        checks++; if (imem.IMem_Addr !== 23'h41) begin errors++; $display("FAIL ign_addr got %0h exp 41", imem.IMem_Addr); end
        checks++; if (IFID_Instr !== 23'd164 || IFID_PCPlus1 !== 23'h41) begin
            errors++; $display("FAIL ign_ifid got %0d/%0h exp 164/41", IFID_Instr, IFID_PCPlus1); end
        IFID_WriteEn = 1'b1;
        tick();
        checks++; if (IFID_Instr !== 23'd165 || IFID_PCPlus1 !== 23'h42) begin
            errors++; $display("FAIL ign_release got %0d/%0h exp 165/42", IFID_Instr, IFID_PCPlus1); end
    endtask

    task automatic test_not_ready();
        r_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++; if (IFID_Valid !== 1'b0 || IFID_Instr !== 23'd0) begin
                errors++; $display("FAIL nr_bubble[%0d] got %0h/%0h exp 0/0", c, IFID_Valid, IFID_Instr); end
            checks++; if (imem.IMem_Addr !== 23'h42) begin errors++; $display("FAIL nr_addr[%0d] got %0h exp 42", c, imem.IMem_Addr); end
        end
        r_ready = 1'b1;
        tick();
        checks++; if (IFID_Instr !== 23'd166 || IFID_PCPlus1 !== 23'h43 || IFID_Valid !== 1'b1) begin
            errors++; $display("FAIL nr_resume got %0d/%0h/%0h exp 166/43/1", IFID_Instr, IFID_PCPlus1, IFID_Valid); end
    endtask

    task automatic test_wrap();
        Redirect = 1'b1; Redirect_Target = 23'h7FFFFF;
        tick();
        Redirect = 1'b0;
        checks++; if (imem.IMem_Addr !== 23'h7FFFFF) begin errors++; $display("FAIL wrap_addr got %0h exp 7fffff", imem.IMem_Addr); end
        tick();
        checks++; if (IFID_PCPlus1 !== 23'd0 || IFID_Instr !== 23'd99 || IFID_Valid !== 1'b1) begin
            errors++; $display("FAIL wrap_ifid got %0h/%0d/%0h exp 0/99/1", IFID_PCPlus1, IFID_Instr, IFID_Valid); end
        checks++; if (imem.IMem_Addr !== 23'd0) begin errors++; $display("FAIL wrap_next_addr got %0h exp 0", imem.IMem_Addr); end
    endtask

    task automatic test_reset_in_hold();
        r_ovr_en = 1'b1; r_ovr_data = 23'd7;
        PCWriteEn = 1'b0; IFID_WriteEn = 1'b0;
        tick();
        r_ovr_en = 1'b0;
        checks++; if (imem.IMem_Req !== 1'b0) begin errors++; $display("FAIL rh_in_hold_req got %0h exp 0", imem.IMem_Req); end
        rst = 1'b1;
        tick();
        checks++; if (IFID_Valid !== 1'b0 || IFID_Instr !== 23'd0 || IFID_PCPlus1 !== 23'd0) begin
            errors++; $display("FAIL rh_outputs got %0h/%0h/%0h exp 0/0/0", IFID_Valid, IFID_Instr, IFID_PCPlus1); end
        checks++; if (imem.IMem_Req !== 1'b0 || imem.IMem_Addr !== 23'd0) begin
            errors++; $display("FAIL rh_imem got req %0h addr %0h exp 0/0", imem.IMem_Req, imem.IMem_Addr); end
        rst = 1'b0; PCWriteEn = 1'b1; IFID_WriteEn = 1'b1;
        #1;
        checks++; if (imem.IMem_Req !== 1'b1) begin errors++; $display("FAIL rh_req_after got %0h exp 1", imem.IMem_Req); end
        tick();
        checks++; if (IFID_Instr !== 23'd100 || IFID_PCPlus1 !== 23'd1) begin
            errors++; $display("FAIL rh_buffer_discard got %0d/%0d exp 100/1", IFID_Instr, IFID_PCPlus1); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_redirect_ignored();
        test_not_ready();
        test_wrap();
        test_reset_in_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
